// File: rtl/lasertag_pkg.sv
// rtl/lasertag_pkg.sv - shared state codes, widths and default timing for the laser-tag unit
package lasertag_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FIRE     = 3'd1,
    ST_COOLDOWN = 3'd2,
    ST_RELOAD   = 3'd3,
    ST_DEAD     = 3'd4
  } state_t;

  localparam int AMMO_W   = 4;
  localparam int HEALTH_W = 4;

  // Defaults assume a 50 MHz system clock.
  localparam int DEF_FIRE_CYCLES     = 50000;
  localparam int DEF_COOLDOWN_CYCLES = 12500000;
  localparam int DEF_RELOAD_CYCLES   = 100000000;
  localparam int DEF_INVULN_CYCLES   = 50000000;
  localparam int DEF_MAX_AMMO        = 8;
  localparam int DEF_MAX_HEALTH      = 5;
  localparam int DEF_CNT_W           = 27;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter that parks at zero and flags it
module phase_timer #(
  parameter int CNT_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load wins; otherwise count down and stop at zero so the counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/shot_ctrl.sv
// rtl/shot_ctrl.sv - weapon/health sequencer: fire, cooldown, reload, hits and death
module shot_ctrl
  import lasertag_pkg::*;
#(
  parameter int FIRE_CYCLES     = DEF_FIRE_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int RELOAD_CYCLES   = DEF_RELOAD_CYCLES,
  parameter int INVULN_CYCLES   = DEF_INVULN_CYCLES,
  parameter int MAX_AMMO        = DEF_MAX_AMMO,
  parameter int MAX_HEALTH      = DEF_MAX_HEALTH,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                CLR,
  input  logic                shot,
  input  logic                hit,
  input  logic                reload_req,
  output logic                laser_on,
  output logic [AMMO_W-1:0]   ammo,
  output logic [HEALTH_W-1:0] health,
  output logic                dead,
  output logic                busy,
  output logic [2:0]          state,
  output logic                hit_pulse,
  output logic                empty_click
);

  localparam logic [AMMO_W-1:0]   AMMO_FULL   = AMMO_W'(MAX_AMMO);
  localparam logic [HEALTH_W-1:0] HEALTH_FULL = HEALTH_W'(MAX_HEALTH);

  state_t              state_q, state_d;
  logic [AMMO_W-1:0]   ammo_q, ammo_d;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic                laser_on_q, laser_on_d;
  logic                busy_q, busy_d;
  logic                dead_q, dead_d;
  logic                hit_pulse_q, hit_pulse_d;
  logic                empty_click_q, empty_click_d;
  logic                shot_prev_q, hit_prev_q;

  logic                shot_rise, hit_rise, hit_ok;
  logic                phase_load, phase_zero;
  logic [CNT_W-1:0]    phase_val;
  logic                inv_load, inv_zero;

  assign shot_rise = shot & ~shot_prev_q;
  assign hit_rise  = hit & ~hit_prev_q;

  phase_timer #(.CNT_W(CNT_W)) u_phase (
    .clk      (clk),
    .rst      (CLR),
    .load     (phase_load),
    .load_val (phase_val),
    .zero     (phase_zero)
  );

  phase_timer #(.CNT_W(CNT_W)) u_invuln (
    .clk      (clk),
    .rst      (CLR),
    .load     (inv_load),
    .load_val (CNT_W'(INVULN_CYCLES - 1)),
    .zero     (inv_zero)
  );

  // Weapon sequencing, parallel hit handling, and a fatal hit overriding everything.
  always_comb begin
    state_d       = state_q;
    ammo_d        = ammo_q;
    health_d      = health_q;
    hit_pulse_d   = 1'b0;
    empty_click_d = 1'b0;
    phase_load    = 1'b0;
    phase_val     = '0;
    inv_load      = 1'b0;

    hit_ok = (state_q != ST_DEAD) && hit_rise && inv_zero && (health_q != '0);

    case (state_q)
      ST_IDLE: begin
        if (shot_rise) begin
          if (ammo_q != '0) begin
            state_d    = ST_FIRE;
            ammo_d     = ammo_q - AMMO_W'(1);
            phase_load = 1'b1;
            phase_val  = CNT_W'(FIRE_CYCLES - 1);
          end else begin
            empty_click_d = 1'b1;
          end
        end else if (reload_req && (ammo_q < AMMO_FULL)) begin
          state_d    = ST_RELOAD;
          phase_load = 1'b1;
          phase_val  = CNT_W'(RELOAD_CYCLES - 1);
        end
      end
      ST_FIRE: begin
        if (phase_zero) begin
          state_d    = ST_COOLDOWN;
          phase_load = 1'b1;
          phase_val  = CNT_W'(COOLDOWN_CYCLES - 1);
        end
      end
      ST_COOLDOWN: begin
        if (phase_zero) begin
          state_d = ST_IDLE;
        end
      end
      ST_RELOAD: begin
        if (phase_zero) begin
          state_d = ST_IDLE;
          ammo_d  = AMMO_FULL;
        end
      end
      ST_DEAD: begin
        state_d = ST_DEAD;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (hit_ok) begin
      health_d    = health_q - HEALTH_W'(1);
      hit_pulse_d = 1'b1;
      inv_load    = 1'b1;
      // Last point of health: abandon whatever the weapon was doing this cycle.
      if (health_q == HEALTH_W'(1)) begin
        state_d       = ST_DEAD;
        ammo_d        = ammo_q;
        empty_click_d = 1'b0;
        phase_load    = 1'b0;
      end
    end

    laser_on_d = (state_d == ST_FIRE);
    busy_d     = (state_d == ST_FIRE) || (state_d == ST_COOLDOWN) || (state_d == ST_RELOAD);
    dead_d     = (state_d == ST_DEAD);
  end

  // State and registered outputs; prev flops reset high so held inputs make no edge.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state_q       <= ST_IDLE;
      ammo_q        <= AMMO_FULL;
      health_q      <= HEALTH_FULL;
      laser_on_q    <= 1'b0;
      busy_q        <= 1'b0;
      dead_q        <= 1'b0;
      hit_pulse_q   <= 1'b0;
      empty_click_q <= 1'b0;
      shot_prev_q   <= 1'b1;
      hit_prev_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      ammo_q        <= ammo_d;
      health_q      <= health_d;
      laser_on_q    <= laser_on_d;
      busy_q        <= busy_d;
      dead_q        <= dead_d;
      hit_pulse_q   <= hit_pulse_d;
      empty_click_q <= empty_click_d;
      shot_prev_q   <= shot;
      hit_prev_q    <= hit;
    end
  end

  assign laser_on    = laser_on_q;
  assign ammo        = ammo_q;
  assign health      = health_q;
  assign dead        = dead_q;
  assign busy        = busy_q;
  assign state       = state_q;
  assign hit_pulse   = hit_pulse_q;
  assign empty_click = empty_click_q;

endmodule

// File: tb/tb_shot_ctrl.sv
// tb/tb_shot_ctrl.sv - directed self-checking bench for shot_ctrl
module tb_shot_ctrl;

  logic       clk = 1'b0;
  logic       CLR = 1'b1;
  logic       shot = 1'b0;
  logic       hit = 1'b0;
  logic       reload_req = 1'b0;
  logic       laser_on, dead, busy, hit_pulse, empty_click;
  logic [3:0] ammo, health;
  logic [2:0] state;

  int n_checks = 0;
  int n_pass   = 0;
  int laser_cnt, busy_cnt, rel_cnt, click_cnt, pulse_cnt, first_laser, last_laser, tick_idx;

  shot_ctrl #(
    .FIRE_CYCLES     (4),
    .COOLDOWN_CYCLES (6),
    .RELOAD_CYCLES   (10),
    .INVULN_CYCLES   (8),
    .MAX_AMMO        (2),
    .MAX_HEALTH      (2),
    .CNT_W           (5)
  ) dut (
    .clk         (clk),
    .CLR         (CLR),
    .shot        (shot),
    .hit         (hit),
    .reload_req  (reload_req),
    .laser_on    (laser_on),
    .ammo        (ammo),
    .health      (health),
    .dead        (dead),
    .busy        (busy),
    .state       (state),
    .hit_pulse   (hit_pulse),
    .empty_click (empty_click)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    laser_cnt = 0; busy_cnt = 0; rel_cnt = 0; click_cnt = 0; pulse_cnt = 0;
    first_laser = -1; last_laser = -1; tick_idx = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (laser_on) begin
        laser_cnt++;
        if (first_laser < 0) first_laser = tick_idx;
        last_laser = tick_idx;
      end
      if (busy) busy_cnt++;
      if (state == 3'd3) rel_cnt++;
      if (empty_click) click_cnt++;
      if (hit_pulse) pulse_cnt++;
      tick_idx++;
    end
  endtask

  task automatic do_reset();
    shot = 0; hit = 0; reload_req = 0;
    CLR = 1;
    tick();
    tick();
    CLR = 0;
    tick();
  endtask

  initial begin
    clr_counts();
    // Reset values
    tick();
    tick();
    check("rst_state", state, 0);
    check("rst_laser", laser_on, 0);
    check("rst_ammo", ammo, 2);
    check("rst_health", health, 2);
    check("rst_dead", dead, 0);
    check("rst_busy", busy, 0);
    check("rst_click", empty_click, 0);
    check("rst_pulse", hit_pulse, 0);
    CLR = 0;
    tick();

    // 1: single shot, 3-cycle trigger
    shot = 1;
    clr_counts();
    for (int i = 0; i < 20; i++) begin
      run(1);
      if (i == 2) shot = 0;
    end
    check("s1_first_laser", first_laser, 0);
    check("s1_last_laser", last_laser, 3);
    check("s1_laser_cnt", laser_cnt, 4);
    check("s1_busy_cnt", busy_cnt, 10);
    check("s1_ammo", ammo, 1);
    check("s1_state", state, 0);

    // 2: empty magazine, empty click, reload
    shot = 1; run(1); shot = 0; run(11);
    check("s2_ammo0", ammo, 0);
    check("s2_idle", state, 0);
    shot = 1; run(1);
    check("s2_click", empty_click, 1);
    check("s2_click_laser", laser_on, 0);
    check("s2_click_state", state, 0);
    run(1);
    check("s2_click_once", empty_click, 0);
    shot = 0;
    clr_counts();
    reload_req = 1; run(1);
    check("s2_reload_state", state, 3);
    check("s2_reload_ammo", ammo, 0);
    reload_req = 0; run(12);
    check("s2_reload_len", rel_cnt, 10);
    check("s2_refill", ammo, 2);
    reload_req = 1; run(2);
    check("s2_full_reload_ign", state, 0);
    reload_req = 0;

    // 3: trigger dropped in cooldown, held trigger needs fresh edge
    shot = 1; run(1); shot = 0; run(5);
    check("s3_in_cool", state, 2);
    check("s3_ammo1", ammo, 1);
    clr_counts();
    shot = 1; run(1); shot = 0; run(5);
    check("s3_cool_no_laser", laser_cnt, 0);
    check("s3_cool_ammo", ammo, 1);
    check("s3_cool_idle", state, 0);
    clr_counts();
    shot = 1; run(13);
    check("s3_held_laser", laser_cnt, 4);
    check("s3_held_ammo", ammo, 0);
    check("s3_held_noclick", click_cnt, 0);
    check("s3_held_idle", state, 0);
    shot = 0; run(1);
    clr_counts();
    shot = 1; run(1);
    check("s3_fresh_edge", click_cnt, 1);
    shot = 0; reload_req = 1; run(1); reload_req = 0; run(11);
    check("s3_refill", ammo, 2);

    // 4: hits, invulnerability window, death
    clr_counts();
    hit = 1; run(1);
    check("s4_health1", health, 1);
    check("s4_pulse", hit_pulse, 1);
    hit = 0; run(2);
    hit = 1; run(1);
    check("s4_invuln_health", health, 1);
    check("s4_invuln_nopulse", hit_pulse, 0);
    hit = 0; run(5);
    hit = 1; run(1);
    check("s4_health0", health, 0);
    check("s4_dead", dead, 1);
    check("s4_state_dead", state, 4);
    check("s4_pulse_cnt", pulse_cnt, 2);
    check("s4_busy_dead", busy, 0);
    hit = 0;

    // 5: killed during reload, dead state frozen
    do_reset();
    hit = 1; run(1); hit = 0;
    shot = 1; run(1); shot = 0; run(11);
    shot = 1; run(1); shot = 0; run(11);
    check("s5_ammo0", ammo, 0);
    reload_req = 1; run(1); reload_req = 0; run(3);
    check("s5_reloading", state, 3);
    hit = 1; run(1);
    check("s5_state_dead", state, 4);
    check("s5_ammo_kept", ammo, 0);
    check("s5_health0", health, 0);
    check("s5_dead", dead, 1);
    check("s5_busy", busy, 0);
    hit = 0;
    clr_counts();
    shot = 1; reload_req = 1; run(3);
    hit = 1; run(2);
    shot = 0; reload_req = 0; hit = 0; run(15);
    check("s5_frozen_state", state, 4);
    check("s5_frozen_ammo", ammo, 0);
    check("s5_frozen_health", health, 0);
    check("s5_frozen_laser", laser_cnt, 0);
    check("s5_frozen_pulse", pulse_cnt, 0);
    check("s5_frozen_click", click_cnt, 0);
    check("s5_frozen_dead", dead, 1);

    // 6: asynchronous clear mid-fire, held trigger across reset
    do_reset();
    shot = 1; run(1); shot = 0; run(1);
    check("s6_firing", laser_on, 1);
    CLR = 1;
    #2;
    check("s6_async_laser", laser_on, 0);
    check("s6_async_state", state, 0);
    shot = 1;
    tick();
    CLR = 0;
    check("s6_ammo", ammo, 2);
    check("s6_health", health, 2);
    check("s6_dead", dead, 0);
    clr_counts();
    run(5);
    check("s6_held_nofire", laser_cnt, 0);
    shot = 0; run(1);
    shot = 1; run(1);
    check("s6_refire_laser", laser_on, 1);
    check("s6_refire_ammo", ammo, 1);
    shot = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shot_ctrl.md
Name: shot_ctrl

Overview:
Game-level weapon/health controller for the laser-tag unit. It consumes the debounced trigger level from `gun` and the stretched hit level from `sensor`. It sequences the laser emitter through fire, cooldown and reload phases, tracks ammo and health, and latches a dead state. It sits between the input conditioners and the display/emitter drivers.

Parameters:
FIRE_CYCLES, 50000, laser-on duration per shot in clk cycles (1 ms @ 50 MHz)
COOLDOWN_CYCLES, 12500000, dead time after each shot before the next shot is accepted
RELOAD_CYCLES, 100000000, reload duration
INVULN_CYCLES, 50000000, hit-ignore window after a registered hit
MAX_AMMO, 8, magazine size (1..15)
MAX_HEALTH, 5, starting health (1..15)
CNT_W, 27, phase/invuln counter width; must hold the largest cycle parameter

Ports:
clk  in  1  system clock
CLR  in  1  reset, asynchronous, active-high
shot  in  1  debounced trigger level from `gun`, active high
hit  in  1  stretched hit level from `sensor`, active high
reload_req  in  1  reload button level, already debounced
laser_on  out  1  emitter enable
ammo  out  4  rounds remaining
health  out  4  health remaining
dead  out  1  sticky game-over flag
busy  out  1  high in FIRE, COOLDOWN or RELOAD
state  out  3  current FSM state code
hit_pulse  out  1  one-cycle strobe per registered hit
empty_click  out  1  one-cycle strobe on trigger with zero ammo

Behaviour:
- Reset values (async on CLR high):
  - state=IDLE, laser_on=0, ammo=MAX_AMMO, health=MAX_HEALTH.
  - dead=0, busy=0, hit_pulse=0, empty_click=0.
  - phase counter=0, invuln counter=0.
  - shot_prev=1 and hit_prev=1, so inputs held through reset do not generate edges.
- Edges: `shot_rise = shot & ~shot_prev` and `hit_rise = hit & ~hit_prev`; both prev registers update every cycle.
- Outputs are registered. `laser_on` is high exactly when state==FIRE.
- State codes: IDLE=0, FIRE=1, COOLDOWN=2, RELOAD=3, DEAD=4.
- IDLE:
  - `shot_rise` with ammo>0 -> FIRE. On the same edge: ammo-1, phase counter loaded with FIRE_CYCLES-1.
  - `shot_rise` with ammo==0 -> empty_click=1 for one cycle; stay IDLE.
  - Otherwise `reload_req` high with ammo<MAX_AMMO -> RELOAD; phase counter loaded with RELOAD_CYCLES-1.
  - `reload_req` with ammo==MAX_AMMO is ignored.
  - If `shot_rise` and `reload_req` arrive together with ammo>0, fire wins.
- FIRE: counter decrements each cycle. At 0 -> COOLDOWN, counter loaded with COOLDOWN_CYCLES-1. laser_on is high for exactly FIRE_CYCLES cycles.
- COOLDOWN: at counter 0 -> IDLE.
- RELOAD: at counter 0 -> IDLE and ammo=MAX_AMMO on that edge.
- Trigger edges in FIRE, COOLDOWN or RELOAD are dropped, not queued. The first shot after COOLDOWN needs a fresh rising edge.
- Hit handling runs in parallel with the weapon FSM in every state except DEAD.
  - Condition: `hit_rise` while invuln counter==0 and health>0.
  - Effect: health-1, hit_pulse=1 for one cycle, invuln counter loaded with INVULN_CYCLES-1.
  - A nonzero invuln counter decrements every cycle. `hit_rise` during invuln is ignored with no pulse.
- Death:
  - When a registered hit takes health 1->0, the next state is DEAD on that same edge, from any state.
  - This aborts FIRE, COOLDOWN and RELOAD; laser_on drops with the state change.
  - An aborted reload does not refill ammo.
  - A shot edge in that same cycle is ignored.
- DEAD: dead=1, busy=0, laser_on=0. All inputs are ignored; ammo and health are frozen. Only CLR exits.
- Counters never wrap: decrement only when nonzero. ammo and health never go below 0.
- CLR mid-operation drops laser_on immediately (asynchronous) and restores all reset values.

Decomposition:
- Shared package `lasertag_pkg`:
  - state encodings (IDLE..DEAD);
  - default cycle constants;
  - AMMO_W and HEALTH_W = 4.
- One sub-module `phase_timer`: load/decrement down-counter with a `zero` flag, parameterised by CNT_W. It is instantiated twice (phase and invuln).
- Edge detection stays inline.

Test Plan:
Sim parameters for all scenarios: FIRE=4, COOLDOWN=6, RELOAD=10, INVULN=8, MAX_AMMO=2, MAX_HEALTH=2.
1. Release CLR, pulse shot high 3 cycles -> laser_on high exactly 4 cycles starting 1 cycle after the rise; ammo 2->1; busy high 10 cycles; then state=0.
2. Two shots spaced for full cooldown -> ammo=0. Third shot -> empty_click one cycle, laser_on stays 0. Then reload_req -> state=3 for 10 cycles, then ammo=2.
3. Shot rise during COOLDOWN -> no laser, ammo unchanged. Shot held high from FIRE through the end of COOLDOWN -> no second shot until shot falls and rises again.
4. Hit rise -> health 2->1, one hit_pulse. Second hit rise 3 cycles later -> ignored. Hit rise 9 cycles after the first -> health=0, dead=1, state=4.
5. Kill during RELOAD (ammo=0) -> state=4, ammo stays 0. Subsequent shot, hit and reload_req -> no output changes.
6. Assert CLR asynchronously mid-FIRE -> laser_on=0 before the next clk edge. After release: ammo=2, health=2, dead=0. shot held high across reset -> no fire until it falls and re-rises.
